// File: rtl/frame_sched_pkg.sv
// ============================================================================
// Module : frame_sched_pkg
// Brief  : Shared defaults and one-hot state encodings for the frame command
//          scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package frame_sched_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DATA_W      = 64;
    localparam int DEF_TIMEOUT_CYC = 1024;

    localparam int ST_W = 4;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t IDLE  = 4'b0001;
    localparam state_t ISSUE = 4'b0010;
    localparam state_t WAIT  = 4'b0100;
    localparam state_t RESP  = 4'b1000;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick, searching upward from last_grant+1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    int               cand_i;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand_i  = 0;
        cand    = '0;
        // Offset NUM_REQ lands on last_grant itself, so it is checked last.
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_i = (int'(last_grant) + off) % NUM_REQ;
            cand   = IDX_W'(cand_i);
            if (!any && req[cand]) begin
                any          = 1'b1;
                gnt_oh[cand] = 1'b1;
                gnt_idx      = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_cmd_scheduler.sv
// ============================================================================
// Module : frame_cmd_scheduler
// Brief  : Arbitrates requesters onto one engine, tracks completion/timeout
//          and returns a one-hot response to the granted requester.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module frame_cmd_scheduler
    import frame_sched_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_cmd,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        eng_valid,
    output logic [DATA_W-1:0]           eng_cmd,
    input  logic                        eng_ready,
    input  logic                        eng_done,
    input  logic                        eng_err,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic                        rsp_err,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = ($clog2(TIMEOUT_CYC) > 16) ? $clog2(TIMEOUT_CYC) : 16;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [IDX_W-1:0]      grant_id_q, grant_id_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  eng_valid_q, eng_valid_d;
    logic [DATA_W-1:0]     eng_cmd_q, eng_cmd_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  busy_q, busy_d;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_any;
    logic                  accept;
    logic                  timeout;
    logic [DATA_W-1:0]     cmd_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign cmd_arr[gi] = req_cmd[gi*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt_oh     (arb_gnt),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

    assign accept    = (state_q == IDLE) && arb_any;
    assign timeout   = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign req_ready = accept ? arb_gnt : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // eng_done is only looked at in WAIT and wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_any)              state_d = ISSUE;
            ISSUE:   if (eng_ready)            state_d = WAIT;
            WAIT:    if (eng_done || timeout)  state_d = RESP;
            RESP:                              state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // Outputs are registered from state_d so they line up with the new state.
    always_comb begin
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        eng_cmd_d    = eng_cmd_q;
        rsp_err_d    = rsp_err_q;
        rsp_valid_d  = '0;
        cnt_d        = (state_q == WAIT) ? cnt_q + CNT_W'(1) : '0;
        eng_valid_d  = (state_d == ISSUE);
        busy_d       = (state_d != IDLE);
        if (accept) begin
            last_grant_d = arb_idx;
            grant_id_d   = arb_idx;
            eng_cmd_d    = cmd_arr[arb_idx];
        end
        if (state_d == RESP) begin
            rsp_valid_d[grant_id_q] = 1'b1;
            rsp_err_d               = eng_done ? eng_err : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            cnt_q        <= '0;
            eng_valid_q  <= 1'b0;
            eng_cmd_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            cnt_q        <= cnt_d;
            eng_valid_q  <= eng_valid_d;
            eng_cmd_q    <= eng_cmd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign eng_valid = eng_valid_q;
    assign eng_cmd   = eng_cmd_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_cmd_scheduler.sv
// ============================================================================
// Module : tb_frame_cmd_scheduler
// Brief  : Directed, table-driven self-checking bench for frame_cmd_scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_frame_cmd_scheduler;

    localparam int NR = 4;
    localparam int DW = 64;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*DW-1:0] req_cmd;
    logic [NR-1:0]   req_ready;
    logic            eng_valid;
    logic [DW-1:0]   eng_cmd;
    logic            eng_ready = 1'b0;
    logic            eng_done = 1'b0;
    logic            eng_err = 1'b0;
    logic [NR-1:0]   rsp_valid;
    logic            rsp_err;
    logic [1:0]      grant_id;
    logic            busy;

    logic [DW-1:0]   cur_cmd [NR];
    logic [DW-1:0]   cmds [NR];

    assign req_cmd = {cur_cmd[3], cur_cmd[2], cur_cmd[1], cur_cmd[0]};

    always #5 clk = ~clk;

    frame_cmd_scheduler #(
        .NUM_REQ     (NR),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_cmd   (req_cmd),
        .req_ready (req_ready),
        .eng_valid (eng_valid),
        .eng_cmd   (eng_cmd),
        .eng_ready (eng_ready),
        .eng_done  (eng_done),
        .eng_err   (eng_err),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0] rv;
        int         rdy_dly;
        int         done_dly;   // -1: never signal done, expect timeout
        logic       err;
        int         exp_g;
        logic       exp_e;
    } vec_t;

    vec_t vecs [11];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Entered and left at a negedge with the DUT in IDLE.
    task automatic do_txn(input vec_t v);
        logic [3:0]  oh;
        logic [63:0] ec;
        int          n;
        oh = 4'b0001 << v.exp_g;
        ec = cmds[v.exp_g];
        req_valid = v.rv;
        #1;
        chk("req_ready", 64'(req_ready), 64'(oh));
        chk("busy_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        req_valid = ~v.rv;
        cur_cmd[v.exp_g] = ~ec;
        @(negedge clk);
        chk("eng_valid_issue", 64'(eng_valid), 64'd1);
        chk("eng_cmd", eng_cmd, ec);
        chk("grant_id", 64'(grant_id), 64'(v.exp_g));
        chk("busy_issue", 64'(busy), 64'd1);
        for (int i = 0; i < v.rdy_dly; i++) begin
            eng_ready = 1'b0;
            eng_done  = (i == 0);
            eng_err   = (i == 0);
            @(negedge clk);
            chk("eng_valid_stall", 64'(eng_valid), 64'd1);
            chk("eng_cmd_stall", eng_cmd, ec);
            chk("rsp_valid_stall", 64'(rsp_valid), 64'd0);
        end
        eng_done  = 1'b0;
        eng_err   = 1'b0;
        eng_ready = 1'b1;
        @(negedge clk);
        eng_ready = 1'b0;
        chk("eng_valid_wait", 64'(eng_valid), 64'd0);
        if (v.done_dly >= 0) begin
            repeat (v.done_dly) begin
                chk("rsp_valid_wait", 64'(rsp_valid), 64'd0);
                @(negedge clk);
            end
            eng_done = 1'b1;
            eng_err  = v.err;
            @(negedge clk);
            eng_done = 1'b0;
            eng_err  = 1'b0;
        end else begin
            n = 0;
            while (rsp_valid == '0 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_latency", 64'(n + 1), 64'(TO + 1));
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(oh));
        chk("rsp_err", 64'(rsp_err), 64'(v.exp_e));
        chk("busy_resp", 64'(busy), 64'd1);
        @(negedge clk);
        chk("rsp_valid_after", 64'(rsp_valid), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
        cur_cmd[v.exp_g] = ec;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cmds[0] = 64'h0000_0000_0000_00A5;
        cmds[1] = 64'h0123_4567_89AB_CDEF;
        cmds[2] = 64'hDEAD_BEEF_0000_0002;
        cmds[3] = 64'hFFFF_0000_FFFF_0003;
        for (int i = 0; i < NR; i++) cur_cmd[i] = cmds[i];

        //            rv       rdy dn  err g  e
        vecs[0]  = '{4'b1111,  0,  2, 1'b0, 0, 1'b0};
        vecs[1]  = '{4'b1111,  1,  0, 1'b1, 1, 1'b1};
        vecs[2]  = '{4'b1111,  0,  4, 1'b0, 2, 1'b0};
        vecs[3]  = '{4'b1111,  2,  1, 1'b0, 3, 1'b0};
        vecs[4]  = '{4'b1111,  0,  0, 1'b0, 0, 1'b0};
        vecs[5]  = '{4'b0001,  0,  2, 1'b0, 0, 1'b0};
        vecs[6]  = '{4'b1010, 10,  1, 1'b0, 1, 1'b0};
        vecs[7]  = '{4'b0101,  0, -1, 1'b0, 2, 1'b1};
        vecs[8]  = '{4'b1001,  0,  7, 1'b0, 3, 1'b0};
        vecs[9]  = '{4'b0110,  0,  7, 1'b1, 1, 1'b1};
        vecs[10] = '{4'b0100,  3,  0, 1'b0, 2, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_eng_valid", 64'(eng_valid), 64'd0);
        chk("rst_eng_cmd", eng_cmd, 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stray done while idle must not produce a response.
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        chk("idle_done_rsp", 64'(rsp_valid), 64'd0);
        chk("idle_done_busy", 64'(busy), 64'd0);

        for (int k = 0; k < 11; k++) do_txn(vecs[k]);
        req_valid = '0;

        // Reset while in WAIT abandons the command and restarts priority at 0.
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        chk("rstw_req_ready", 64'(req_ready), 64'd2);
        @(negedge clk);
        req_valid = '0;
        chk("rstw_eng_valid", 64'(eng_valid), 64'd1);
        eng_ready = 1'b1;
        @(negedge clk);
        eng_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstw_busy", 64'(busy), 64'd0);
        chk("rstw_eng_valid0", 64'(eng_valid), 64'd0);
        chk("rstw_eng_cmd", eng_cmd, 64'd0);
        chk("rstw_grant_id", 64'(grant_id), 64'd0);
        repeat (TO + 2) begin
            chk("rstw_no_rsp", 64'(rsp_valid), 64'd0);
            @(negedge clk);
        end
        do_txn('{4'b1111, 0, 1, 1'b0, 0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
